// File: rtl/led_cmd_controller_if.sv
// Byte-stream, reply and PWM-drive signals of the LED command sequencer.
// The controller takes the slave side; the UART/PWM wrapper (or a bench) takes the master side.
interface led_cmd_controller_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] duty;
    logic       fading;
    logic       cmd_error;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, duty, fading, cmd_error
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, duty, fading, cmd_error
    );
endinterface

// File: rtl/led_cmd_controller.sv
// LED duty sequencer: parses 'S' V, 'F' T R and '?' from the UART byte stream,
// runs a per-PWM-period linear fade and answers duty queries on the TX side.
module led_cmd_controller #(
    parameter int DUTY_MAX       = 100,
    parameter int PERIOD_CYCLES  = 101,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    led_cmd_controller_if.slave bus
);
    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       DMAX    = 8'(DUTY_MAX);

    localparam logic [7:0] OP_SET   = 8'h53;
    localparam logic [7:0] OP_FADE  = 8'h46;
    localparam logic [7:0] OP_QUERY = 8'h3F;

    typedef enum logic [2:0] {IDLE, GET_VAL, GET_TGT, GET_RATE, REPLY} state_t;

    state_t           r_state;
    logic [PER_W-1:0] r_per_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_duty;
    logic [7:0]       r_tgt;
    logic [7:0]       r_new_tgt;
    logic [7:0]       r_rate;
    logic [7:0]       r_rate_cnt;
    logic             r_fading;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             r_err;

    logic       w_tick;
    logic       w_cmd_apply;
    logic [8:0] w_rate_nxt;
    logic       w_step;
    logic [7:0] w_duty_step;
    logic [7:0] w_rx_clamped;

    function automatic logic [7:0] f_clamp(input logic [7:0] v);
        return (v > DMAX) ? DMAX : v;
    endfunction

    assign w_tick       = (r_per_cnt == PER_MAX);
    // A completing S/F command owns duty and fade state this cycle; any coincident step is dropped.
    assign w_cmd_apply  = bus.rx_valid && ((r_state == GET_VAL) || (r_state == GET_RATE));
    assign w_rate_nxt   = {1'b0, r_rate_cnt} + 9'd1;
    assign w_step       = r_fading && w_tick && (w_rate_nxt == {1'b0, r_rate});
    assign w_duty_step  = (r_duty < r_tgt) ? (r_duty + 8'd1) : (r_duty - 8'd1);
    assign w_rx_clamped = f_clamp(bus.rx_data);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_per_cnt <= '0;
        end else if (w_tick) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_to_cnt   <= '0;
            r_duty     <= '0;
            r_tgt      <= '0;
            r_new_tgt  <= '0;
            r_rate     <= '0;
            r_rate_cnt <= '0;
            r_fading   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;

            if (r_fading && w_tick && !w_cmd_apply) begin
                if (w_step) begin
                    r_duty     <= w_duty_step;
                    r_rate_cnt <= '0;
                    if (w_duty_step == r_tgt)
                        r_fading <= 1'b0;
                end else begin
                    r_rate_cnt <= w_rate_nxt[7:0];
                end
            end

            unique case (r_state)
                IDLE: begin
                    r_to_cnt <= '0;
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            OP_SET:   r_state <= GET_VAL;
                            OP_FADE:  r_state <= GET_TGT;
                            OP_QUERY: begin
                                r_tx_data  <= r_duty;
                                r_tx_valid <= 1'b1;
                                r_state    <= REPLY;
                            end
                            default:  r_state <= IDLE;
                        endcase
                    end
                end

                GET_VAL, GET_TGT, GET_RATE: begin
                    if (bus.rx_valid) begin
                        r_to_cnt <= '0;
                        r_state  <= IDLE;
                        if (r_state == GET_VAL) begin
                            r_duty     <= w_rx_clamped;
                            r_fading   <= 1'b0;
                            r_rate_cnt <= '0;
                        end else if (r_state == GET_TGT) begin
                            // Held aside so an aborted parse leaves a running fade untouched.
                            r_new_tgt <= w_rx_clamped;
                            r_state   <= GET_RATE;
                        end else begin
                            r_tgt      <= r_new_tgt;
                            r_rate     <= bus.rx_data;
                            r_rate_cnt <= '0;
                            if (bus.rx_data == 8'd0) begin
                                r_duty   <= r_new_tgt;
                                r_fading <= 1'b0;
                            end else begin
                                r_fading <= (r_new_tgt != r_duty);
                            end
                        end
                    end else if (r_to_cnt == TO_MAX) begin
                        r_to_cnt <= '0;
                        r_state  <= IDLE;
                        r_err    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                REPLY: begin
                    if (bus.rx_valid)
                        r_err <= 1'b1;
                    if (r_tx_valid && bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.duty      = r_duty;
    assign bus.fading    = r_fading;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.cmd_error = r_err;

endmodule

// File: tb/tb_led_cmd_controller.sv
// Randomized bench for led_cmd_controller against a command-queue reference model.
module tb_led_cmd_controller;
    localparam int PER = 4;
    localparam int TO  = 40;

    logic clk;
    logic reset_n;
    led_cmd_controller_if bus();

    led_cmd_controller #(.DUTY_MAX(100), .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;
    int trdy_mode;

    // Reference model: pending command bytes, reply slot, fade bookkeeping in ticks.
    logic [7:0] m_q[$];
    int         m_edges;
    int         m_idle;
    bit         m_rep;
    logic [7:0] m_txd;
    logic [7:0] m_duty;
    logic [7:0] m_tgt;
    int         m_rate;
    int         m_ticks;
    bit         m_fading;
    bit         m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] clampv(input logic [7:0] v);
        return (v > 8'd100) ? 8'd100 : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_edges = 0; m_idle = 0; m_rep = 0; m_txd = 0;
        m_duty = 0; m_tgt = 0; m_rate = 0; m_ticks = 0; m_fading = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit rv, input logic [7:0] rd, input bit trdy);
        bit applied = 0;
        bit err = 0;
        bit tick;
        logic [7:0] d0 = m_duty;
        logic [7:0] t;
        m_edges++;
        tick = (m_edges % PER) == 0;
        if (m_rep) begin
            if (rv) err = 1;
            if (trdy) m_rep = 0;
        end else if (m_q.size() == 0) begin
            if (rv && (rd == "S" || rd == "F")) begin
                m_q.push_back(rd);
                m_idle = 0;
            end else if (rv && rd == "?") begin
                m_rep = 1;
                m_txd = d0;
            end
        end else if (rv) begin
            m_q.push_back(rd);
            m_idle = 0;
            if (m_q[0] == "S" && m_q.size() == 2) begin
                m_duty = clampv(m_q[1]); m_fading = 0; applied = 1; m_q.delete();
            end else if (m_q[0] == "F" && m_q.size() == 3) begin
                t = clampv(m_q[1]);
                if (m_q[2] == 0) begin
                    m_duty = t; m_fading = 0;
                end else begin
                    m_tgt = t; m_rate = m_q[2]; m_ticks = 0; m_fading = (t != d0);
                end
                applied = 1; m_q.delete();
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_q.delete();
                err = 1;
            end
        end
        if (!applied && m_fading && tick) begin
            m_ticks++;
            if (m_ticks == m_rate) begin
                m_ticks = 0;
                m_duty = (m_duty < m_tgt) ? m_duty + 8'd1 : m_duty - 8'd1;
                if (m_duty == m_tgt) m_fading = 0;
            end
        end
        m_err = err;
    endtask

    task automatic compare_all();
        check("duty", bus.duty, m_duty);
        check("fading", bus.fading, m_fading);
        check("tx_valid", bus.tx_valid, m_rep);
        check("cmd_error", bus.cmd_error, m_err);
        if (m_rep) check("tx_data", bus.tx_data, m_txd);
    endtask

    task automatic cyc();
        bit srv;
        logic [7:0] srd;
        bit strdy;
        case (trdy_mode)
            0: bus.tx_ready = 1'($urandom_range(0, 1));
            1: bus.tx_ready = 1'b0;
            default: bus.tx_ready = 1'b1;
        endcase
        srv = bus.rx_valid; srd = bus.rx_data; strdy = bus.tx_ready;
        @(posedge clk);
        model_edge(srv, srd, strdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cyc();
        bus.rx_valid = 1'b0;
        bus.rx_data  = $urandom_range(0, 255);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        check("rst_tx_data", bus.tx_data, 8'd0);
        repeat (3) @(posedge clk);
        #1 compare_all();
        reset_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_val();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 110));
    endfunction

    function automatic logic [7:0] rnd_rate();
        int r = $urandom_range(0, 9);
        if (r < 5) return 8'($urandom_range(0, 3));
        if (r < 9) return 8'($urandom_range(4, 10));
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic gap_send(input logic [7:0] b);
        idle($urandom_range(0, 2));
        send(b);
    endtask

    initial begin
        n_chk = 0; n_bad = 0; trdy_mode = 2;
        reset_n = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        check("rst_tx_data", bus.tx_data, 8'd0);
        reset_n = 1'b1;

        send("S"); send(8'h32); idle(3);
        send("S"); send(8'hC8); idle(2);
        send("?"); idle(3);
        send("S"); send(8'd10); idle(2);
        send("F"); send(8'd20); send(8'd2); idle(90);
        send("F"); send(8'd5); send(8'd2); idle(130);
        send("F"); idle(TO + 5);
        send("F"); send(8'd90); send(8'd1); idle(30);
        send("S"); send(8'd40); idle(3);
        trdy_mode = 1;
        send("?"); idle(20); send(8'h11); idle(30);
        trdy_mode = 2; idle(3);
        send("F"); send(8'd100); send(8'd1); idle(20);
        send("F"); do_reset();
        send("S"); send(8'd7); idle(3);

        for (int seg = 0; seg < 250; seg++) begin
            int r = $urandom_range(0, 99);
            int k = $urandom_range(0, 9);
            trdy_mode = (k < 7) ? 0 : (k < 9) ? 1 : 2;
            if (r < 8) begin
                send(($urandom_range(0, 1) != 0) ? 8'h46 : 8'h53);
                if ($urandom_range(0, 1) != 0) gap_send(rnd_val());
                idle(TO + $urandom_range(0, 3));
            end else if (r < 12) begin
                idle(200);
            end else if (r < 15) begin
                idle($urandom_range(0, 10));
                do_reset();
            end else begin
                int c = $urandom_range(0, 9);
                if (c < 3) begin
                    gap_send("S"); gap_send(rnd_val());
                end else if (c < 7) begin
                    gap_send("F"); gap_send(rnd_val()); gap_send(rnd_rate());
                end else if (c < 9) begin
                    gap_send("?");
                end else begin
                    gap_send(8'($urandom_range(0, 255)));
                end
                idle($urandom_range(0, 30));
            end
        end
        trdy_mode = 2;
        idle(5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
